// File: rtl/counter_modn_cascade_if.sv
// Bus interface for counter_modn_cascade: control, load data and count/status outputs.
// The driver of the controls uses master; the counter core uses slave.
interface counter_modn_cascade_if #(
    parameter int unsigned NUM_DIGITS = 2,
    parameter int unsigned DW         = 4
);
    logic                       loadn;
    logic                       en;
    logic                       up;
    logic [NUM_DIGITS*DW-1:0]   CNT_in;
    logic [NUM_DIGITS*DW-1:0]   CNT;
    logic                       tc;
    logic                       zero;

    modport master (
        output loadn, en, up, CNT_in,
        input  CNT, tc, zero
    );

    modport slave (
        input  loadn, en, up, CNT_in,
        output CNT, tc, zero
    );
endinterface

// File: rtl/counter_modn_cascade.sv
// Multi-digit cascaded modulo-MODULUS up/down counter with clamped parallel load
// and optional saturation at the terminal value.
module counter_modn_cascade #(
    parameter int unsigned MODULUS    = 10,
    parameter int unsigned NUM_DIGITS = 2,
    parameter bit          SATURATE   = 1'b0
) (
    input  logic                   clk,
    input  logic                   clr,
    counter_modn_cascade_if.slave  bus
);
    localparam int unsigned   DW   = (MODULUS > 1) ? $clog2(MODULUS) : 1;
    localparam logic [DW-1:0] MAXV = DW'(MODULUS - 1);

    typedef logic [NUM_DIGITS-1:0][DW-1:0] digits_t;

    digits_t             r_dig;
    digits_t             w_load;
    digits_t             w_step;
    logic [NUM_DIGITS:0] w_lo_max;
    logic [NUM_DIGITS:0] w_lo_zero;
    logic                w_term;
    logic                w_hold;

    always_comb begin : load_clamp
        w_load = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (32'(bus.CNT_in[i*DW +: DW]) >= MODULUS)
                w_load[i] = MAXV;
            else
                w_load[i] = bus.CNT_in[i*DW +: DW];
        end
    end

    // Bit i: every digit below i sits at its carry (max) / borrow (zero) value.
    // Bit NUM_DIGITS therefore flags the whole chain at that value.
    always_comb begin : carry_chain
        logic w_am;
        logic w_az;
        w_lo_max  = '0;
        w_lo_zero = '0;
        w_am      = 1'b1;
        w_az      = 1'b1;
        for (int unsigned i = 0; i <= NUM_DIGITS; i++) begin
            w_lo_max[i]  = w_am;
            w_lo_zero[i] = w_az;
            if (i < NUM_DIGITS) begin
                w_am = w_am & (r_dig[i] == MAXV);
                w_az = w_az & (r_dig[i] == '0);
            end
        end
    end

    always_comb begin : next_count
        w_step = r_dig;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (bus.up) begin
                if (w_lo_max[i])
                    w_step[i] = (r_dig[i] == MAXV) ? '0 : r_dig[i] + DW'(1);
            end else begin
                if (w_lo_zero[i])
                    w_step[i] = (r_dig[i] == '0) ? MAXV : r_dig[i] - DW'(1);
            end
        end
    end

    assign w_term = bus.up ? w_lo_max[NUM_DIGITS] : w_lo_zero[NUM_DIGITS];
    assign w_hold = SATURATE & w_term;

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            r_dig <= '0;
        else if (!bus.loadn)
            r_dig <= w_load;
        else if (bus.en && !w_hold)
            r_dig <= w_step;
    end

    assign bus.CNT  = r_dig;
    assign bus.tc   = bus.en & w_term;
    assign bus.zero = w_lo_zero[NUM_DIGITS];
endmodule

// File: tb/tb_counter_modn_cascade.sv
// Bench for counter_modn_cascade: three parameterisations checked against an
// integer-valued model plus directed literal expectations.
module tb_counter_modn_cascade;
    localparam int PM [3] = '{10, 10, 6};
    localparam int PN [3] = '{2, 2, 3};
    localparam int PS [3] = '{0, 1, 0};
    localparam int PD [3] = '{4, 4, 3};

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        ld   [3];
    logic        en_  [3];
    logic        up_  [3];
    logic [31:0] cin  [3];
    logic [31:0] gcnt [3];
    logic        gtc  [3];
    logic        gz   [3];
    int          mv   [3] = '{0, 0, 0};
    int          errs   = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    counter_modn_cascade_if #(.NUM_DIGITS(2), .DW(4)) if0 ();
    counter_modn_cascade_if #(.NUM_DIGITS(2), .DW(4)) if1 ();
    counter_modn_cascade_if #(.NUM_DIGITS(3), .DW(3)) if2 ();

    counter_modn_cascade #(.MODULUS(10), .NUM_DIGITS(2), .SATURATE(1'b0))
        dut0 (.clk(clk), .clr(clr), .bus(if0));
    counter_modn_cascade #(.MODULUS(10), .NUM_DIGITS(2), .SATURATE(1'b1))
        dut1 (.clk(clk), .clr(clr), .bus(if1));
    counter_modn_cascade #(.MODULUS(6), .NUM_DIGITS(3), .SATURATE(1'b0))
        dut2 (.clk(clk), .clr(clr), .bus(if2));

    assign if0.loadn = ld[0];  assign if0.en = en_[0];  assign if0.up = up_[0];
    assign if1.loadn = ld[1];  assign if1.en = en_[1];  assign if1.up = up_[1];
    assign if2.loadn = ld[2];  assign if2.en = en_[2];  assign if2.up = up_[2];
    assign if0.CNT_in = cin[0][7:0];
    assign if1.CNT_in = cin[1][7:0];
    assign if2.CNT_in = cin[2][8:0];
    assign gcnt[0] = 32'(if0.CNT);  assign gtc[0] = if0.tc;  assign gz[0] = if0.zero;
    assign gcnt[1] = 32'(if1.CNT);  assign gtc[1] = if1.tc;  assign gz[1] = if1.zero;
    assign gcnt[2] = 32'(if2.CNT);  assign gtc[2] = if2.tc;  assign gz[2] = if2.zero;

    // ---------------- model: the count is a single integer in [0, M^N) ----------------
    function automatic int top_of(int k);
        int p = 1;
        for (int i = 0; i < PN[k]; i++) p = p * PM[k];
        return p - 1;
    endfunction

    function automatic int load_val(int k, logic [31:0] c);
        int v = 0;
        for (int i = PN[k] - 1; i >= 0; i--) begin
            int f = int'((c >> (i * PD[k])) & ((32'd1 << PD[k]) - 32'd1));
            if (f >= PM[k]) f = PM[k] - 1;
            v = v * PM[k] + f;
        end
        return v;
    endfunction

    function automatic logic [31:0] enc(int k, int v);
        logic [31:0] r = '0;
        int          t = v;
        for (int i = 0; i < PN[k]; i++) begin
            r = r | (32'(t % PM[k]) << (i * PD[k]));
            t = t / PM[k];
        end
        return r;
    endfunction

    function automatic int nxt(int k, int v);
        int top = top_of(k);
        if (!ld[k]) return load_val(k, cin[k]);
        if (!en_[k]) return v;
        if (up_[k]) begin
            if (v == top) return (PS[k] != 0) ? v : 0;
            return v + 1;
        end
        if (v == 0) return (PS[k] != 0) ? v : top;
        return v - 1;
    endfunction

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int k = 0; k < 3; k++) mv[k] <= 0;
        end else begin
            for (int k = 0; k < 3; k++) mv[k] <= nxt(k, mv[k]);
        end
    end

    always @(negedge clk) begin
        if (!clr) begin
            for (int k = 0; k < 3; k++) begin
                logic etc;
                etc = en_[k] & (up_[k] ? (mv[k] == top_of(k)) : (mv[k] == 0));
                checks = checks + 3;
                if (gcnt[k] !== enc(k, mv[k])) begin
                    errs = errs + 1;
                    $display("FAIL model_cnt[%0d] t=%0t got %h exp %h", k, $time, gcnt[k], enc(k, mv[k]));
                end
                if (gtc[k] !== etc) begin
                    errs = errs + 1;
                    $display("FAIL model_tc[%0d] t=%0t got %b exp %b", k, $time, gtc[k], etc);
                end
                if (gz[k] !== (mv[k] == 0)) begin
                    errs = errs + 1;
                    $display("FAIL model_zero[%0d] t=%0t got %b exp %b", k, $time, gz[k], mv[k] == 0);
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errs = errs + 1;
            $display("FAIL %s t=%0t got %h exp %h", nm, $time, got, exp);
        end
    endtask

    task automatic drv(input int k, input logic l, input logic e, input logic u, input logic [31:0] c);
        ld[k] = l; en_[k] = e; up_[k] = u; cin[k] = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) drv(k, 1'b1, 1'b0, 1'b1, 32'h0);
        drv(0, 1'b1, 1'b1, 1'b0, 32'h0);
        #2;
        chk("rst_cnt0", gcnt[0], 32'h00);
        chk("rst_zero0", 32'(gz[0]), 32'h1);
        chk("rst_tc0_en_down", 32'(gtc[0]), 32'h1);
        chk("rst_tc1_noen", 32'(gtc[1]), 32'h0);
        chk("rst_cnt2", gcnt[2], 32'h0);
        #1 clr = 1'b0;
        drv(0, 1'b1, 1'b0, 1'b1, 32'h0);

        // load and clamp
        drv(0, 1'b0, 1'b0, 1'b1, 32'h37); tick(); chk("load37", gcnt[0], 32'h37);
        drv(0, 1'b0, 1'b1, 1'b1, 32'hAA); tick(); chk("loadAA_clamp", gcnt[0], 32'h99);

        // up wrap
        drv(0, 1'b0, 1'b0, 1'b1, 32'h98); tick(); chk("up_98", gcnt[0], 32'h98);
        drv(0, 1'b1, 1'b1, 1'b1, 32'h0);  tick(); chk("up_99", gcnt[0], 32'h99);
        chk("up_tc99", 32'(gtc[0]), 32'h1);
        tick(); chk("up_00", gcnt[0], 32'h00);
        chk("up_zero00", 32'(gz[0]), 32'h1);
        chk("up_tc00", 32'(gtc[0]), 32'h0);
        tick(); chk("up_01", gcnt[0], 32'h01);
        drv(0, 1'b0, 1'b0, 1'b1, 32'h09); tick();
        drv(0, 1'b1, 1'b1, 1'b1, 32'h0);  tick(); chk("carry_10", gcnt[0], 32'h10);

        // down wrap
        drv(0, 1'b0, 1'b0, 1'b0, 32'h01); tick(); chk("dn_01", gcnt[0], 32'h01);
        drv(0, 1'b1, 1'b1, 1'b0, 32'h0);  tick(); chk("dn_00", gcnt[0], 32'h00);
        chk("dn_tc00", 32'(gtc[0]), 32'h1);
        chk("dn_zero00", 32'(gz[0]), 32'h1);
        tick(); chk("dn_99", gcnt[0], 32'h99);
        drv(0, 1'b0, 1'b0, 1'b0, 32'h10); tick();
        drv(0, 1'b1, 1'b1, 1'b0, 32'h0);  tick(); chk("borrow_09", gcnt[0], 32'h09);

        // asynchronous clear mid-count, between edges
        drv(0, 1'b1, 1'b1, 1'b1, 32'h0);  tick();
        #1 clr = 1'b1;
        #1;
        chk("aclr_cnt0", gcnt[0], 32'h00);
        chk("aclr_zero0", 32'(gz[0]), 32'h1);
        chk("aclr_tc0_up", 32'(gtc[0]), 32'h0);
        #1 clr = 1'b0;
        tick(); chk("aclr_then_01", gcnt[0], 32'h01);
        drv(0, 1'b1, 1'b0, 1'b1, 32'h0);

        // saturation
        drv(1, 1'b0, 1'b0, 1'b0, 32'h02); tick(); chk("sat_02", gcnt[1], 32'h02);
        drv(1, 1'b1, 1'b1, 1'b0, 32'h0);
        tick(); chk("sat_01", gcnt[1], 32'h01);
        tick(); chk("sat_00a", gcnt[1], 32'h00);
        tick(); chk("sat_00b", gcnt[1], 32'h00);
        tick(); chk("sat_00c", gcnt[1], 32'h00);
        drv(1, 1'b1, 1'b1, 1'b1, 32'h0);  tick(); chk("sat_up01", gcnt[1], 32'h01);
        drv(1, 1'b0, 1'b0, 1'b1, 32'h98); tick();
        drv(1, 1'b1, 1'b1, 1'b1, 32'h0);
        tick(); chk("sat_99a", gcnt[1], 32'h99);
        tick(); chk("sat_99b", gcnt[1], 32'h99);
        chk("sat_tc99", 32'(gtc[1]), 32'h1);
        drv(1, 1'b1, 1'b0, 1'b1, 32'h0);

        // MODULUS=6, NUM_DIGITS=3
        drv(2, 1'b0, 1'b0, 1'b1, 32'h0); tick();
        drv(2, 1'b1, 1'b1, 1'b1, 32'h0);
        repeat (215) tick();
        chk("m6_555", gcnt[2], 32'h16D);
        chk("m6_tc555", 32'(gtc[2]), 32'h1);
        tick(); chk("m6_wrap0", gcnt[2], 32'h0);
        chk("m6_zero", 32'(gz[2]), 32'h1);
        drv(2, 1'b0, 1'b0, 1'b1, 32'h1FF); tick(); chk("m6_clamp777", gcnt[2], 32'h16D);
        drv(2, 1'b0, 1'b0, 1'b1, 32'h0B7); tick(); chk("m6_clamp267", gcnt[2], 32'h0AD);

        // randomized traffic on all three counters
        repeat (3000) begin
            for (int k = 0; k < 3; k++)
                drv(k, ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)), $urandom);
            if ($urandom_range(0, 199) == 0) begin
                #1 clr = 1'b1;
                #1 clr = 1'b0;
            end
            tick();
        end

        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
